// File: rtl/spike_peak_tracker.sv
// Tracks the peak per-timestep spike popcount over a run and derives a scaled threshold.
// Optional macro SPT_MEAN_EN adds the run total of per-step popcounts on port total.
`timescale 1ns/1ps
module spike_peak_tracker #(
   parameter int unsigned M         = 784,
   parameter int unsigned STEPS     = 200,
   parameter int unsigned W         = 24,
   parameter int unsigned SCALE_NUM = 21846,
   parameter int unsigned SCALE_SH  = 16,
   localparam int unsigned CW       = $clog2(M + 1),
   localparam int unsigned TW       = CW + $clog2(STEPS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [M-1:0]  spikes,
   input  logic          spikes_valid,
   output logic          gen_start,
   output logic          gen_next,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] peak,
   output logic [W-1:0]  threshold
`ifdef SPT_MEAN_EN
   ,
   output logic [TW-1:0] total
`endif
);

   localparam int unsigned NG   = (M + 31) / 32;
   localparam int unsigned PADW = NG * 32;
   localparam int unsigned PW   = CW + 16;
   localparam int unsigned SW   = $clog2(STEPS + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_RUN,
      S_DRAIN,
      S_SCALE
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] req_cnt_q, req_cnt_d;
   logic [SW-1:0] acc_cnt_q, acc_cnt_d;
   logic          gen_start_q, gen_start_d;
   logic          gen_next_q, gen_next_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [CW-1:0] max_q, max_d;
   logic [CW-1:0] peak_q, peak_d;
   logic [W-1:0]  thr_q, thr_d;

   logic [5:0]    grp_q [NG];
   logic [5:0]    grp_d [NG];
   logic          s1_v_q, s1_v_d;
   logic          s2_v_q, s2_v_d;
   logic [CW-1:0] sum_q, sum_d;

   logic            accept_c;
   logic [PADW-1:0] pad_c;
   logic [PW-1:0]   prod_c;
   logic [PW-1:0]   shr_c;
   logic [W-1:0]    sat_c;

   // Stage 1: per-32-bit group popcounts, last group zero-padded
   always_comb begin
      pad_c = PADW'(spikes);
      for (int g = 0; g < NG; g++) begin
         grp_d[g] = '0;
         for (int b = 0; b < 32; b++) begin
            grp_d[g] = grp_d[g] + 6'(pad_c[g*32 + b]);
         end
      end
   end

   // Stage 2: sum of group counts
   always_comb begin
      sum_d = '0;
      for (int g = 0; g < NG; g++) begin
         sum_d = sum_d + CW'(grp_q[g]);
      end
      s1_v_d = accept_c;
      s2_v_d = s1_v_q;
   end

   assign prod_c = PW'(max_q) * PW'(SCALE_NUM);
   assign shr_c  = prod_c >> SCALE_SH;

   if (W >= PW) begin : g_nosat
      assign sat_c = W'(shr_c);
   end else begin : g_sat
      assign sat_c = (|shr_c[PW-1:W]) ? {W{1'b1}} : shr_c[W-1:0];
   end

   // Run control, request/accept counters and running max
   always_comb begin
      state_d     = state_q;
      req_cnt_d   = req_cnt_q;
      acc_cnt_d   = acc_cnt_q;
      max_d       = max_q;
      peak_d      = peak_q;
      thr_d       = thr_q;
      done_d      = 1'b0;
      gen_start_d = 1'b0;
      gen_next_d  = 1'b0;
      busy_d      = 1'b0;

      accept_c = spikes_valid && (state_q == S_RUN) && (acc_cnt_q < SW'(STEPS));

      if (gen_next_q) req_cnt_d = req_cnt_q + SW'(1);
      if (accept_c)   acc_cnt_d = acc_cnt_q + SW'(1);
      if (s2_v_q && (sum_q > max_q)) max_d = sum_q;

      case (state_q)
         S_IDLE: begin
            // done_q high means the previous run is still finishing this cycle
            if (start && !done_q) state_d = S_START;
         end
         S_START: begin
            state_d   = S_RUN;
            req_cnt_d = '0;
            acc_cnt_d = '0;
            max_d     = '0;
         end
         S_RUN: begin
            if (acc_cnt_d == SW'(STEPS)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (!s1_v_q && !s2_v_q) state_d = S_SCALE;
         end
         S_SCALE: begin
            peak_d  = max_q;
            thr_d   = sat_c;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      gen_start_d = (state_d == S_START);
      gen_next_d  = (state_d == S_RUN) && (req_cnt_d < SW'(STEPS));
      busy_d      = (state_d != S_IDLE) || done_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         req_cnt_q   <= '0;
         acc_cnt_q   <= '0;
         gen_start_q <= 1'b0;
         gen_next_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         max_q       <= '0;
         peak_q      <= '0;
         thr_q       <= '0;
         s1_v_q      <= 1'b0;
         s2_v_q      <= 1'b0;
         sum_q       <= '0;
         for (int g = 0; g < NG; g++) grp_q[g] <= '0;
      end else begin
         state_q     <= state_d;
         req_cnt_q   <= req_cnt_d;
         acc_cnt_q   <= acc_cnt_d;
         gen_start_q <= gen_start_d;
         gen_next_q  <= gen_next_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         max_q       <= max_d;
         peak_q      <= peak_d;
         thr_q       <= thr_d;
         s1_v_q      <= s1_v_d;
         s2_v_q      <= s2_v_d;
         if (accept_c) grp_q <= grp_d;
         if (s1_v_q)   sum_q <= sum_d;
      end
   end

   assign gen_start = gen_start_q;
   assign gen_next  = gen_next_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign peak      = peak_q;
   assign threshold = thr_q;

`ifdef SPT_MEAN_EN
   logic [TW-1:0] tot_acc_q, tot_acc_d;
   logic [TW-1:0] total_q, total_d;

   // Run total accumulates alongside the running max, published with peak
   always_comb begin
      tot_acc_d = tot_acc_q;
      total_d   = total_q;
      if (state_q == S_START) tot_acc_d = '0;
      else if (s2_v_q)        tot_acc_d = tot_acc_q + TW'(sum_q);
      if (state_q == S_SCALE) total_d = tot_acc_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tot_acc_q <= '0;
         total_q   <= '0;
      end else begin
         tot_acc_q <= tot_acc_d;
         total_q   <= total_d;
      end
   end

   assign total = total_q;
`endif

endmodule

// File: tb/tb_spike_peak_tracker.sv
// Scoreboard bench for spike_peak_tracker: directed runs, generator model and done monitors.
// Build with SPT_MEAN_EN defined to also check the run total.
`timescale 1ns/1ps
module tb_spike_peak_tracker;

   localparam int unsigned M     = 784;
   localparam int unsigned STEPS = 200;
   localparam int unsigned W     = 24;
   localparam int unsigned CW    = 10;
   localparam int unsigned TW    = CW + 8;
   localparam int unsigned BW    = 8;
   localparam int unsigned BTW   = CW + 1;

   typedef struct {
      int peak;
      int thr;
      int total;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          start, spikes_valid, gen_start, gen_next, busy, done;
   logic [M-1:0]  spikes;
   logic [CW-1:0] peak;
   logic [W-1:0]  threshold;

   logic          b_start, b_spikes_valid, b_gen_start, b_gen_next, b_busy, b_done;
   logic [M-1:0]  b_spikes;
   logic [CW-1:0] b_peak;
   logic [BW-1:0] b_threshold;

`ifdef SPT_MEAN_EN
   logic [TW-1:0]  total;
   logic [BTW-1:0] b_total;
`endif

   spike_peak_tracker #(.M(M), .STEPS(STEPS), .W(W), .SCALE_NUM(21846), .SCALE_SH(16)) u_dut (
      .clk(clk), .rst(rst), .start(start), .spikes(spikes), .spikes_valid(spikes_valid),
      .gen_start(gen_start), .gen_next(gen_next), .busy(busy), .done(done),
      .peak(peak), .threshold(threshold)
`ifdef SPT_MEAN_EN
      , .total(total)
`endif
   );

   // Saturation corner: narrow output, near-unity scale, single-step run
   spike_peak_tracker #(.M(M), .STEPS(1), .W(BW), .SCALE_NUM(65535), .SCALE_SH(16)) u_dut_sat (
      .clk(clk), .rst(rst), .start(b_start), .spikes(b_spikes), .spikes_valid(b_spikes_valid),
      .gen_start(b_gen_start), .gen_next(b_gen_next), .busy(b_busy), .done(b_done),
      .peak(b_peak), .threshold(b_threshold)
`ifdef SPT_MEAN_EN
      , .total(b_total)
`endif
   );

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   mode = 0;
   bit   gap_mode = 0;
   bit   spur_mode = 0;
   int   idx = 0;
   int   pend = 0;
   int   spur_left = 0;
   int   gen_starts = 0;
   int   last_acc = 0;
   int   done_seen = 0;
   int   b_done_seen = 0;
   bit   tog = 0;
   exp_t exp_q[$];
   exp_t b_exp_q[$];

   task automatic check(input string name, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic fail_now(input string name, input string why);
      checks++;
      errors++;
      $display("FAIL %s: %s", name, why);
   endtask

   function automatic logic [M-1:0] pattern(input int m, input int k);
      logic [M-1:0] v;
      v = '0;
      case (m)
         1: if (k == 37) v = '1;
         2: for (int i = 0; i < M; i++) v[i] = (i < k);
         default: v = '0;
      endcase
      return v;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Generator model: one sample per request, optionally every other cycle, optional strays
   initial begin
      spikes = '0;
      spikes_valid = 1'b0;
      forever begin
         @(negedge clk);
         spikes_valid = 1'b0;
         spikes = '0;
         tog = ~tog;
         if (rst) begin
            pend = 0;
            idx = 0;
            spur_left = 0;
         end else begin
            if (gen_start) begin
               gen_starts++;
               idx = 0;
               pend = 0;
               spur_left = spur_mode ? 5 : 0;
            end
            if (gen_next) pend++;
            if (pend > 0 && (!gap_mode || tog)) begin
               spikes = pattern(mode, idx);
               spikes_valid = 1'b1;
               if (idx == STEPS - 1) last_acc = cyc + 1;
               idx++;
               pend--;
            end else if (idx == STEPS && spur_left > 0) begin
               spikes = '1;
               spikes_valid = 1'b1;
               spur_left--;
            end
         end
      end
   end

   // Main-instance monitor
   initial begin
      exp_t e;
      bit   prev_done;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_done = 1'b0;
         end else begin
            if (prev_done) check("busy_after_done", busy, 0);
            if (done) begin
               done_seen++;
               check("busy_with_done", busy, 1);
               if (exp_q.size() == 0) begin
                  fail_now("unexpected_done", "done=1 with no run outstanding");
               end else begin
                  e = exp_q.pop_front();
                  check("peak", peak, e.peak);
                  check("threshold", threshold, e.thr);
                  check("done_latency", cyc - last_acc, 4);
`ifdef SPT_MEAN_EN
                  check("total", total, e.total);
`endif
               end
            end
            prev_done = done;
         end
      end
   end

   // Saturation-instance monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && b_done) begin
            b_done_seen++;
            if (b_exp_q.size() == 0) begin
               fail_now("sat_unexpected_done", "done=1 with no run outstanding");
            end else begin
               e = b_exp_q.pop_front();
               check("sat_peak", b_peak, e.peak);
               check("sat_threshold", b_threshold, e.thr);
`ifdef SPT_MEAN_EN
               check("sat_total", b_total, e.total);
`endif
            end
         end
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_peak"}, peak, 0);
      check({tag, "_threshold"}, threshold, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_gen_next"}, gen_next, 0);
      check({tag, "_gen_start"}, gen_start, 0);
`ifdef SPT_MEAN_EN
      check({tag, "_total"}, total, 0);
`endif
   endtask

   task automatic run_a(input int m, input bit gap, input bit spur, input bit pester,
                        input int ep, input int et, input int etot, input string tag);
      int n;
      int gs0;
      bit got;
      mode = m;
      gap_mode = gap;
      spur_mode = spur;
      exp_q.push_back('{ep, et, etot});
      gs0 = gen_starts;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      got = 1'b0;
      while (!got && n < 1500) begin
         @(negedge clk);
         n++;
         start = 1'b0;
         if (done) begin
            got = 1'b1;
            if (pester) start = 1'b1;
         end else if (pester && (n == 40 || n == 41)) begin
            start = 1'b1;
         end
      end
      if (!got) begin
         fail_now({tag, "_done_timeout"}, "no done within cycle budget");
         exp_q.delete();
      end
      @(negedge clk); start = 1'b0;
      repeat (6) @(negedge clk);
      check({tag, "_gen_start_count"}, gen_starts - gs0, 1);
      check({tag, "_busy_idle"}, busy, 0);
   endtask

   task automatic reset_midrun();
      int n;
      int d0;
      mode = 2;
      gap_mode = 0;
      spur_mode = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (idx < 100 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) fail_now("midrun_wait_timeout", "generator never reached step 100");
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check_zero("midrun_rst");
      @(negedge clk);
      rst = 1'b0;
      d0 = done_seen;
      repeat (300) @(negedge clk);
      check("no_done_after_abort", done_seen - d0, 0);
   endtask

   task automatic run_b();
      int n;
      int d0;
      d0 = b_done_seen;
      b_exp_q.push_back('{784, 255, 784});
      @(negedge clk); b_start = 1'b1;
      @(negedge clk); b_start = 1'b0;
      n = 0;
      while (!b_gen_next && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!b_gen_next) fail_now("sat_gen_next_timeout", "no request from single-step run");
      b_spikes = '1;
      b_spikes_valid = 1'b1;
      @(negedge clk);
      b_spikes = '0;
      b_spikes_valid = 1'b0;
      n = 0;
      while (b_done_seen == d0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (b_done_seen == d0) begin
         fail_now("sat_done_timeout", "no done within cycle budget");
         b_exp_q.delete();
      end
   endtask

   initial begin
      start = 1'b0;
      b_start = 1'b0;
      b_spikes = '0;
      b_spikes_valid = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      run_a(0, 0, 0, 0, 0,   0,   0,     "zero");
      run_a(1, 0, 0, 0, 784, 261, 784,   "onehot");
      run_a(2, 0, 0, 0, 199, 66,  19900, "ramp");
      run_a(2, 1, 1, 0, 199, 66,  19900, "ramp_gap");
      reset_midrun();
      run_a(2, 0, 0, 1, 199, 66,  19900, "ramp_pester");
      run_b();
      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
